// File: rtl/gpio_out_arbiter_pkg.sv
// Shared types and helpers for the GPIO output arbiter.
// Holds the FSM state enum, the one-hot helper and the round-robin pick.
package gpio_arb_pkg;

    // Largest requester count the helper functions handle.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             any;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scans ptr+1, ptr+2, ... mod nreq. The scan runs backwards so the
    // last hit written is the first one in round-robin order.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int                 nreq
    );
        rr_pick_t         r;
        int               i;
        logic [IDX_W-1:0] sel;
        r = '0;
        for (int k = nreq; k >= 1; k--) begin
            i   = (int'(ptr) + k) % nreq;
            sel = IDX_W'(i);
            if (valid[sel]) begin
                r.any = 1'b1;
                r.idx = sel;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gpio_out_arbiter_if.sv
// Requester-side bundle of the GPIO arbiter: per-requester valid/data
// from the sources, one-hot ready back from the arbiter.
interface gpio_out_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/gpio_out_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter, reusable for any shared resource.
// Ports: valid_i/ptr_i in; pick_o (one-hot), idx_o, any_o out.
module rr_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] pick_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [MAX_REQ-1:0] valid_ext;
    rr_pick_t           r;

    assign valid_ext = MAX_REQ'(valid_i);
    assign r         = rr_pick(valid_ext, IDX_W'(ptr_i), NREQ);

    assign any_o  = r.any;
    assign idx_o  = IW'(r.idx);
    assign pick_o = r.any ? NREQ'(onehot(r.idx)) : '0;

endmodule

// File: rtl/gpio_out_arbiter.sv
// Shares the GPIO header between NREQ requesters, round-robin, holding
// each granted word for HOLD_CYCLES clocks. Ports: CLOCK_50, Resetn,
// req (valid/data/ready bundle), GPIO, grant, busy (all registered).
module gpio_out_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int               NREQ        = 4,
    parameter int               WIDTH       = 32,
    parameter int               HOLD_CYCLES = 50,
    parameter logic [WIDTH-1:0] IDLE_VALUE  = '0
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    gpio_out_arbiter_if.slave req,
    output logic [WIDTH-1:0] GPIO,
    output logic [NREQ-1:0]  grant,
    output logic             busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] PTR_RST  = IW'(NREQ - 1);

    arb_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] gpio_q, gpio_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  pick;
    logic [IW-1:0]    win_idx;
    logic             any_v;
    logic             window;
    logic             accept;
    logic [WIDTH-1:0] win_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .valid_i (req.req_valid),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .idx_o   (win_idx),
        .any_o   (any_v)
    );

    // The last hold cycle doubles as an accept slot, so back-to-back
    // words run exactly HOLD_CYCLES clocks with no idle gap.
    assign window = (state_q == IDLE) || (cnt_q == '0);

    // Reset gates ready so no word can be taken while Resetn is low.
    assign req.req_ready = (Resetn && window && any_v) ? pick : '0;

    assign accept   = |(req.req_valid & req.req_ready);
    assign win_data = req.req_data[win_idx*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gpio_d  = gpio_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        if (accept) begin
            gpio_d  = win_data;
            grant_d = pick;
            ptr_d   = win_idx;
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
            state_d = HOLD;
        end else if (state_q == HOLD) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                // Nobody waiting: release the header but keep its word.
                state_d = IDLE;
                busy_d  = 1'b0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= PTR_RST;
            gpio_q  <= IDLE_VALUE;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gpio_q  <= gpio_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign GPIO  = gpio_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_gpio_out_arbiter.sv
// Bench for gpio_out_arbiter: two instances (hold 4 and hold 1) share
// stimulus and are checked every cycle against a timestamp-based model.
module tb_gpio_out_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   tv;
    logic [127:0] td;

    int nvec = 0;
    int nerr = 0;
    bit run  = 1'b0;

    always #5 clk = ~clk;

    gpio_out_arbiter_if #(.NREQ(4), .WIDTH(32)) if4 ();
    gpio_out_arbiter_if #(.NREQ(4), .WIDTH(32)) if1 ();

    assign if4.req_valid = tv;
    assign if4.req_data  = td;
    assign if1.req_valid = tv;
    assign if1.req_data  = td;

    logic [31:0] g4, g1;
    logic [3:0]  gr4, gr1;
    logic        b4, b1;

    gpio_out_arbiter #(
        .NREQ(4), .WIDTH(32), .HOLD_CYCLES(4), .IDLE_VALUE(32'h0)
    ) dut4 (
        .CLOCK_50 (clk),
        .Resetn   (rst_n),
        .req      (if4),
        .GPIO     (g4),
        .grant    (gr4),
        .busy     (b4)
    );

    gpio_out_arbiter #(
        .NREQ(4), .WIDTH(32), .HOLD_CYCLES(1), .IDLE_VALUE(32'h0)
    ) dut1 (
        .CLOCK_50 (clk),
        .Resetn   (rst_n),
        .req      (if1),
        .GPIO     (g1),
        .grant    (gr1),
        .busy     (b1)
    );

    logic [31:0] dg[2];
    logic [3:0]  dgr[2];
    logic        db[2];
    logic [3:0]  drdy[2];

    assign dg[0]   = g4;
    assign dg[1]   = g1;
    assign dgr[0]  = gr4;
    assign dgr[1]  = gr1;
    assign db[0]   = b4;
    assign db[1]   = b1;
    assign drdy[0] = if4.req_ready;
    assign drdy[1] = if1.req_ready;

    // Model: a word accepted at edge number t may be replaced at any
    // edge e with e - t >= H. An idle arbiter may accept at any edge.
    int          H[2] = '{4, 1};
    logic [31:0] m_gpio[2];
    logic [3:0]  m_grant[2];
    bit          m_busy[2];
    int          m_ptr[2];
    longint      m_t[2];
    longint      cyc = 0;

    function automatic int mpick(int d, logic [3:0] v);
        logic [1:0] j;
        for (int k = 1; k <= 4; k++) begin
            j = 2'((m_ptr[d] + k) % 4);
            if (v[j]) return int'(j);
        end
        return -1;
    endfunction

    function automatic bit mopen(int d);
        return !m_busy[d] || (cyc - m_t[d] >= longint'(H[d]));
    endfunction

    function automatic logic [3:0] mready(int d);
        int p;
        if (!rst_n || !mopen(d)) return 4'b0;
        p = mpick(d, tv);
        return (p < 0) ? 4'b0 : 4'(1 << p);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_gpio[d]  <= 32'h0;
                m_grant[d] <= 4'h0;
                m_busy[d]  <= 1'b0;
                m_ptr[d]   <= 3;
                m_t[d]     <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (mopen(d)) begin
                    if (mpick(d, tv) >= 0) begin
                        m_gpio[d]  <= td[mpick(d, tv)*32 +: 32];
                        m_grant[d] <= 4'(1 << mpick(d, tv));
                        m_ptr[d]   <= mpick(d, tv);
                        m_busy[d]  <= 1'b1;
                        m_t[d]     <= cyc;
                    end else begin
                        m_busy[d]  <= 1'b0;
                        m_grant[d] <= 4'h0;
                    end
                end
            end
            cyc <= cyc + 1;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ready%0d", d), 32'(drdy[d]), 32'(mready(d)));
                chk($sformatf("gpio%0d", d), dg[d], m_gpio[d]);
                chk($sformatf("grant%0d", d), 32'(dgr[d]), 32'(m_grant[d]));
                chk($sformatf("busy%0d", d), 32'(db[d]), 32'(m_busy[d]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        tv    = 4'h0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int  rdy_cnt;
    bit  seen;

    initial begin
        rst_n = 1'b0;
        tv    = 4'hF;
        td    = {32'd4, 32'd3, 32'd2, 32'd1};
        repeat (2) tick();
        run = 1'b1;

        // Reset with every requester valid.
        chk("rst_gpio", g4, 32'h0);
        chk("rst_grant", 32'(gr4), 32'h0);
        chk("rst_busy", 32'(b4), 32'h0);
        chk("rst_ready", 32'(if4.req_ready), 32'h0);
        tv    = 4'h0;
        rst_n = 1'b1;
        tick();

        // Single requester, full hold then release.
        tv        = 4'b0001;
        td        = '0;
        td[31:0]  = 32'hA5A5_0001;
        #1;
        chk("t2_ready", 32'(if4.req_ready), 32'h1);
        tick();
        tv = 4'h0;
        chk("t2_gpio", g4, 32'hA5A5_0001);
        chk("t2_grant", 32'(gr4), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_busy_hold", 32'(b4), 32'h1);
        end
        tick();
        chk("t2_busy_end", 32'(b4), 32'h0);
        chk("t2_grant_end", 32'(gr4), 32'h0);
        chk("t2_gpio_kept", g4, 32'hA5A5_0001);

        // All valid: 1,2,3,4,1 each for exactly 4 cycles.
        pulse_reset();
        td      = {32'd4, 32'd3, 32'd2, 32'd1};
        tv      = 4'hF;
        rdy_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (if4.req_ready != 4'h0) rdy_cnt++;
            tick();
            chk("t3_seq", g4, 32'((t / 4) % 4 + 1));
            chk("t3_busy", 32'(b4), 32'h1);
        end
        chk("t3_ready_pulses", 32'(rdy_cnt), 32'd5);

        // Hold of one: grants alternate every cycle.
        pulse_reset();
        tv = 4'b1010;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t4_grant", 32'(gr1), (k % 2 == 1) ? 32'h2 : 32'h8);
            chk("t4_busy", 32'(b1), 32'h1);
        end

        // Reset in the middle of a hold.
        pulse_reset();
        tv          = 4'b0100;
        td[95:64]   = 32'hC0DE_0002;
        tick();
        tv = 4'h0;
        chk("t5_grant", 32'(gr4), 32'h4);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_gpio_rst", g4, 32'h0);
        chk("t5_busy_rst", 32'(b4), 32'h0);
        tv = 4'b0101;
        #1;
        chk("t5_ready_rst", 32'(if4.req_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_first", 32'(gr4), 32'h1);

        // Late requester drops out before the window opens.
        pulse_reset();
        tv        = 4'b0001;
        td[31:0]  = 32'h600D_0000;
        tick();
        tv        = 4'b0010;
        td[31:0]  = 32'hDEAD_0000;
        seen      = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (if4.req_ready[1]) seen = 1'b1;
            tick();
        end
        tv = 4'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (if4.req_ready[1]) seen = 1'b1;
            tick();
        end
        chk("t6_no_ready1", 32'(seen), 32'h0);
        chk("t6_busy", 32'(b4), 32'h0);
        chk("t6_gpio", g4, 32'h600D_0000);
        chk("t6_grant", 32'(gr4), 32'h0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) tv = 4'($urandom_range(0, 15));
            td = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
